segment_swap_scheduler: RTL
===========================

SEGMENT_SWAP_SCHEDULER -- requirements
Module: segment_swap_scheduler

Interface
REQ-001 SHALL have parameter CycleWidth, default 16, width of index and cycle values.
REQ-002 SHALL have parameter RepWidth, default 16, width of repetition count; all-ones means infinite.
REQ-003 SHALL have port CLK  input  1  single clock for all logic.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port UPDATE_SETTINGS  input  1  one-cycle pulse that latches a segment-change request.
REQ-006 SHALL have port REQ_RD_SEGMENT  input  1  requested segment.
REQ-007 SHALL have port TRANSITION_MODE  input  8  0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO, 0xF0 EXT.
REQ-008 SHALL have port TRANSITION_VALUE  input  64  trigger time (SYS_TIME mode) or GPIO select in bits [1:0] (GPIO mode).
REQ-009 SHALL have port REP  input  RepWidth  number of loops minus one for the new segment.
REQ-010 SHALL have port SYS_TIME  input  64  free-running system time.
REQ-011 SHALL have port GPIO_IN  input  4  synchronous trigger inputs.
REQ-012 SHALL have port IDX_TICK  input  1  pulse when the index counter advances.
REQ-013 SHALL have port IDX  input  CycleWidth  current index of the playing segment.
REQ-014 SHALL have ports CYCLE0, CYCLE1  input  CycleWidth  last valid index of segment 0 and segment 1.
REQ-015 SHALL have port SEGMENT  output  1  segment currently playing.
REQ-016 SHALL have port SWAP  output  1  one-cycle pulse; the index counter restarts at 0 on it.
REQ-017 SHALL have port STOP  output  1  high when finite repetitions are exhausted; the index counter holds.
REQ-018 SHALL have port BUSY  output  1  high while a request is pending.
REQ-019 SHALL have port ERR  output  1  sticky flag set by an invalid TRANSITION_MODE.

Function
REQ-020 SHALL use three states: PLAY, WAIT and STOPPED.
REQ-021 SHALL define loop end as IDX_TICK high with IDX equal to CYCLE of the playing segment.
REQ-022 On UPDATE_SETTINGS with a valid mode, SHALL latch segment, mode, value and REP, then enter WAIT with BUSY high from the next cycle.
REQ-023 On UPDATE_SETTINGS with an invalid mode, SHALL ignore the request, set ERR and leave state unchanged.
REQ-024 In WAIT with SYNC_IDX mode, SHALL trigger at the next loop end.
REQ-025 In WAIT with SYS_TIME mode, SHALL trigger when SYS_TIME is greater than or equal to TRANSITION_VALUE (unsigned); a value already in the past triggers in the first WAIT cycle.
REQ-026 In WAIT with GPIO mode, SHALL trigger on a rising edge of GPIO_IN[TRANSITION_VALUE[1:0]]; the edge register SHALL be reset to 0 and sampled every cycle.
REQ-027 In WAIT with EXT mode, SHALL trigger at the next loop end.
REQ-028 On a trigger detected in cycle N, SHALL update SEGMENT, pulse SWAP, clear BUSY and STOP, load the loop counter with 0 and enter PLAY, all registered at N+1.
REQ-029 In PLAY with finite REP, SHALL increment the loop counter at each loop end; at the loop end where the counter equals REP, SHALL enter STOPPED with STOP high at the next cycle.
REQ-030 In PLAY with REP all-ones, SHALL never stop.
REQ-031 In PLAY with EXT mode latched, SHALL behave as REP loops, then toggle SEGMENT with a SWAP pulse instead of stopping, repeating indefinitely until a new UPDATE_SETTINGS.
REQ-032 If a trigger and a loop end occur in the same cycle, SHALL let the trigger win; the old segment's loop counter SHALL not advance.
REQ-033 If UPDATE_SETTINGS occurs in WAIT, SHALL replace the pending request; the old request SHALL never fire.
REQ-034 If UPDATE_SETTINGS coincides with a trigger of the pending request, SHALL execute the trigger and then latch the new request into WAIT.
REQ-035 SHALL treat a request for the segment already playing as a restart: SWAP pulses and the loop counter reloads.
REQ-036 SHALL accept UPDATE_SETTINGS in STOPPED; STOP stays high until its trigger.

Reset
REQ-037 While RST_N is low, SHALL force SEGMENT=0, SWAP=0, STOP=0, BUSY=0, ERR=0, state PLAY, infinite repetition, pending request cleared.
REQ-038 SHALL discard an in-progress WAIT when reset asserts mid-operation, with no SWAP after release.

Verification
REQ-039 Bench: CYCLE0=3; SYNC_IDX request to segment 1 with REP=all-ones at IDX=1 -> SWAP one cycle after the tick at IDX=3, SEGMENT=1.
REQ-040 Bench: SYS_TIME mode, value 1000, SYS_TIME counting from 990 -> SWAP in the cycle after SYS_TIME=1000; with value 5 -> SWAP in the cycle after entering WAIT.
REQ-041 Bench: CYCLE1=1, REP=2 -> STOP rises one cycle after the third loop end and stays high; further IDX_TICKs cause no change.
REQ-042 Bench: GPIO mode, TRANSITION_VALUE=2, pulse GPIO_IN[1] then GPIO_IN[2] -> no trigger on bit 1; SWAP one cycle after bit 2 rises; mode 0x07 -> ERR=1 and no state change.
REQ-043 Bench: EXT mode, REP=0, CYCLE0=CYCLE1=1 -> SEGMENT toggles at every loop end; a second UPDATE_SETTINGS in WAIT overrides; reset mid-WAIT leaves SEGMENT=0 with no SWAP.

Source files
------------

// File: rtl/segment_swap_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | segment_swap_scheduler                                                   |
// | Schedules segment swaps by index, system time, GPIO edge or ext looping. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module segment_swap_scheduler #(
  parameter int CycleWidth = 16,
  parameter int RepWidth   = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  UPDATE_SETTINGS,
  input  logic                  REQ_RD_SEGMENT,
  input  logic [7:0]            TRANSITION_MODE,
  input  logic [63:0]           TRANSITION_VALUE,
  input  logic [RepWidth-1:0]   REP,
  input  logic [63:0]           SYS_TIME,
  input  logic [3:0]            GPIO_IN,
  input  logic                  IDX_TICK,
  input  logic [CycleWidth-1:0] IDX,
  input  logic [CycleWidth-1:0] CYCLE0,
  input  logic [CycleWidth-1:0] CYCLE1,
  output logic                  SEGMENT,
  output logic                  SWAP,
  output logic                  STOP,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam logic [1:0] c_S_PLAY    = 2'd0;
  localparam logic [1:0] c_S_WAIT    = 2'd1;
  localparam logic [1:0] c_S_STOPPED = 2'd2;

  localparam logic [7:0] c_MODE_SYNC_IDX = 8'h00;
  localparam logic [7:0] c_MODE_SYS_TIME = 8'h01;
  localparam logic [7:0] c_MODE_GPIO     = 8'h02;
  localparam logic [7:0] c_MODE_EXT      = 8'hF0;

  localparam logic [RepWidth-1:0] c_REP_INF = '1;

  logic [1:0]            r_state;
  logic                  r_segment;
  logic                  r_swap;
  logic                  r_stop;
  logic                  r_err;
  logic [RepWidth-1:0]   r_loop_cnt;
  logic [RepWidth-1:0]   r_act_rep;
  logic                  r_act_ext;
  logic                  r_pend_seg;
  logic [7:0]            r_pend_mode;
  logic [63:0]           r_pend_value;
  logic [RepWidth-1:0]   r_pend_rep;
  logic [3:0]            r_gpio_q;

  logic [1:0]            w_next_state;
  logic [CycleWidth-1:0] w_cycle_sel;
  logic                  w_loop_end;
  logic                  w_mode_valid;
  logic                  w_accept;
  logic                  w_gpio_rise;
  logic                  w_trigger;
  logic                  w_loops_done;
  logic                  w_segment_d;
  logic                  w_swap_d;
  logic                  w_stop_d;
  logic                  w_err_d;
  logic [RepWidth-1:0]   w_loop_cnt_d;
  logic [RepWidth-1:0]   w_act_rep_d;
  logic                  w_act_ext_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= c_S_PLAY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_cycle_sel  = r_segment ? CYCLE1 : CYCLE0;
    w_loop_end   = IDX_TICK && (IDX == w_cycle_sel);
    w_mode_valid = (TRANSITION_MODE == c_MODE_SYNC_IDX) || (TRANSITION_MODE == c_MODE_SYS_TIME) ||
                   (TRANSITION_MODE == c_MODE_GPIO)     || (TRANSITION_MODE == c_MODE_EXT);
    w_accept     = UPDATE_SETTINGS && w_mode_valid;
    w_gpio_rise  = GPIO_IN[r_pend_value[1:0]] && !r_gpio_q[r_pend_value[1:0]];

    w_trigger = 1'b0;
    if (r_state == c_S_WAIT) begin
      case (r_pend_mode)
        c_MODE_SYS_TIME: w_trigger = (SYS_TIME >= r_pend_value);
        c_MODE_GPIO:     w_trigger = w_gpio_rise;
        default:         w_trigger = w_loop_end;
      endcase
    end

    // Only PLAY counts loops; a pending request freezes the old segment's count.
    w_loops_done = (r_state == c_S_PLAY) && w_loop_end && (r_act_rep != c_REP_INF) &&
                   (r_loop_cnt == r_act_rep);

    w_next_state = r_state;
    if (w_accept) begin
      w_next_state = c_S_WAIT;
    end else begin
      case (r_state)
        c_S_PLAY: if (w_loops_done && !r_act_ext) w_next_state = c_S_STOPPED;
        c_S_WAIT: if (w_trigger) w_next_state = c_S_PLAY;
        default:  w_next_state = r_state;
      endcase
    end
  end

  always_comb begin
    w_segment_d  = r_segment;
    w_swap_d     = 1'b0;
    w_stop_d     = r_stop;
    w_err_d      = r_err || (UPDATE_SETTINGS && !w_mode_valid);
    w_loop_cnt_d = r_loop_cnt;
    w_act_rep_d  = r_act_rep;
    w_act_ext_d  = r_act_ext;

    if (w_trigger) begin
      w_segment_d  = r_pend_seg;
      w_swap_d     = 1'b1;
      w_stop_d     = 1'b0;
      w_loop_cnt_d = '0;
      w_act_rep_d  = r_pend_rep;
      w_act_ext_d  = (r_pend_mode == c_MODE_EXT);
    end else if (w_loops_done) begin
      if (r_act_ext) begin
        w_segment_d  = !r_segment;
        w_swap_d     = 1'b1;
        w_loop_cnt_d = '0;
      end else begin
        w_stop_d = 1'b1;
      end
    end else if ((r_state == c_S_PLAY) && w_loop_end && (r_act_rep != c_REP_INF)) begin
      w_loop_cnt_d = r_loop_cnt + 1'b1;
    end

    SEGMENT = r_segment;
    SWAP    = r_swap;
    STOP    = r_stop;
    BUSY    = (r_state == c_S_WAIT);
    ERR     = r_err;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_segment    <= 1'b0;
      r_swap       <= 1'b0;
      r_stop       <= 1'b0;
      r_err        <= 1'b0;
      r_loop_cnt   <= '0;
      r_act_rep    <= c_REP_INF;
      r_act_ext    <= 1'b0;
      r_pend_seg   <= 1'b0;
      r_pend_mode  <= c_MODE_SYNC_IDX;
      r_pend_value <= '0;
      r_pend_rep   <= '0;
      r_gpio_q     <= '0;
    end else begin
      r_segment  <= w_segment_d;
      r_swap     <= w_swap_d;
      r_stop     <= w_stop_d;
      r_err      <= w_err_d;
      r_loop_cnt <= w_loop_cnt_d;
      r_act_rep  <= w_act_rep_d;
      r_act_ext  <= w_act_ext_d;
      r_gpio_q   <= GPIO_IN;
      if (w_accept) begin
        r_pend_seg   <= REQ_RD_SEGMENT;
        r_pend_mode  <= TRANSITION_MODE;
        r_pend_value <= TRANSITION_VALUE;
        r_pend_rep   <= REP;
      end
    end
  end

endmodule
`default_nettype wire
